// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers for the add/sub datapath blocks: width helper,
// saturation patterns and flag bit positions.
package fxp_pkg;

  localparam int FLG_OVF = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_W   = 2;
  localparam int SAT_W   = 64;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } fxp_mode_e;

  typedef logic [FLG_W-1:0] fxp_flags_t;

  function automatic int fxp_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Patterns are produced at SAT_W and narrowed by the caller.
  function automatic logic [SAT_W-1:0] sat_smax(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_smin(input int w);
    return SAT_W'(1) << (w - 1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_umax(input int w);
    return (SAT_W'(1) << w) - SAT_W'(1);
  endfunction

endpackage

// File: rtl/fxp_sub_pipe_if.sv
// Operand/result stream bundle for the fixed-point subtractor.
interface fxp_sub_pipe_if #(
  parameter int A_W = 9,
  parameter int B_W = 9,
  parameter int D_W = 10
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           sign_sub;
  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] diff;
  logic           overflow;
  logic           underflow;

  modport master (
    output in_valid, a, b, sign_sub, out_ready,
    input  in_ready, out_valid, diff, overflow, underflow
  );

  modport slave (
    input  in_valid, a, b, sign_sub, out_ready,
    output in_ready, out_valid, diff, overflow, underflow
  );
endinterface

// File: rtl/fxp_sat_trunc.sv
// Combinational saturate/truncate/jam of an exact two's-complement value with
// HF fractional bits into a Q(OUT_I).(OUT_F) result.
module fxp_sat_trunc import fxp_pkg::*; #(
  parameter int EW    = 10,
  parameter int HF    = 5,
  parameter int OUT_I = 5,
  parameter int OUT_F = 5
) (
  input  logic signed [EW-1:0]          x,
  input  fxp_mode_e                     mode,
  output logic        [OUT_I+OUT_F-1:0] y,
  output fxp_flags_t                    flags
);

  localparam int IW = EW - HF;
  localparam int OW = OUT_I + OUT_F;
  // One spare bit above OUT_I keeps the unsigned range test slice non-empty.
  localparam int XI = fxp_max(IW, OUT_I + 1);

  localparam logic [OW-1:0] SMAX = OW'(sat_smax(OW));
  localparam logic [OW-1:0] SMIN = OW'(sat_smin(OW));
  localparam logic [OW-1:0] UMAX = OW'(sat_umax(OW));

  logic signed [IW-1:0]       ip;
  logic signed [XI-1:0]       ip_x;
  logic        [XI-OUT_I:0]   top_s;
  logic        [XI-OUT_I-1:0] top_u;
  logic        [OUT_F-1:0]    frac;
  logic                       unf;
  logic                       neg;
  logic                       fit_s;
  logic                       fit_u;
  logic                       ovf;

  assign ip    = x[EW-1:HF];
  assign ip_x  = XI'(ip);
  assign neg   = x[EW-1];
  assign top_s = ip_x[XI-1:OUT_I-1];
  assign top_u = ip_x[XI-1:OUT_I];
  assign fit_s = (&top_s) | ~(|top_s);
  assign fit_u = ~neg & ~(|top_u);
  assign ovf   = (mode == MODE_SIGNED) ? ~fit_s : ~fit_u;

  if (OUT_F >= HF) begin : g_pad
    assign frac = OUT_F'(x[HF-1:0]) << (OUT_F - HF);
    assign unf  = 1'b0;
  end else begin : g_trunc
    // Dropping low bits of a two's-complement value rounds toward -infinity.
    assign frac = x[HF-1 -: OUT_F];
    assign unf  = |x[HF-OUT_F-1:0];
  end

  always_comb begin
    y = {ip_x[OUT_I-1:0], frac};
    if (ovf) begin
      if (mode == MODE_SIGNED) y = neg ? SMIN : SMAX;
      else                     y = neg ? '0   : UMAX;
    end else if (unf) begin
      y[0] = 1'b1;
    end
    flags          = '0;
    flags[FLG_OVF] = ovf;
    flags[FLG_UNF] = unf;
  end

endmodule

// File: rtl/fxp_sub_pipe.sv
// Three-stage fixed-point subtractor diff = a - b with saturation, truncation
// jamming, per-result flags and sticky status.
module fxp_sub_pipe import fxp_pkg::*; #(
  parameter int I1    = 4,
  parameter int F1    = 5,
  parameter int I2    = 4,
  parameter int F2    = 5,
  parameter int OUT_I = 5,
  parameter int OUT_F = 5
) (
  input  logic           clk,
  input  logic           rst,
  fxp_sub_pipe_if.slave  bus,
  input  logic           clr_sticky,
  output logic           sticky_ovf,
  output logic           sticky_unf
);

  localparam int AW = I1 + F1;
  localparam int BW = I2 + F2;
  localparam int HI = fxp_max(I1, I2);
  localparam int HF = fxp_max(F1, F2);
  localparam int AL = HI + HF;
  localparam int EW = HI + HF + 1;
  localparam int OW = OUT_I + OUT_F;

  logic                 adv;
  logic                 fire;
  logic [AL-1:0]        a_ext;
  logic [AL-1:0]        b_ext;
  logic [AL-1:0]        a_al_p0;
  logic [AL-1:0]        b_al_p0;
  fxp_mode_e            mode_p0;
  fxp_mode_e            mode_p1;
  logic [EW-1:0]        a_sx;
  logic [EW-1:0]        b_sx;
  logic signed [EW-1:0] diff_p1;
  logic [OW-1:0]        st_y;
  fxp_flags_t           st_flags;
  logic [OW-1:0]        diff_p2;
  fxp_flags_t           flags_p2;
  logic                 vld_p0;
  logic                 vld_p1;
  logic                 vld_p2;

  assign adv          = ~vld_p2 | bus.out_ready;
  assign fire         = vld_p2 & bus.out_ready;
  assign bus.in_ready = adv;

  // S1 align: extend integer part to HI bits, pad fraction to HF bits.
  assign a_ext = bus.sign_sub ? AL'($signed(bus.a)) : AL'(bus.a);
  assign b_ext = bus.sign_sub ? AL'($signed(bus.b)) : AL'(bus.b);

  // S2 subtract: one extra bit makes the difference exact in either mode.
  assign a_sx = {(mode_p0 == MODE_SIGNED) & a_al_p0[AL-1], a_al_p0};
  assign b_sx = {(mode_p0 == MODE_SIGNED) & b_al_p0[AL-1], b_al_p0};

  always_ff @(posedge clk) begin
    if (adv) begin
      a_al_p0 <= a_ext << (HF - F1);
      b_al_p0 <= b_ext << (HF - F2);
      mode_p0 <= fxp_mode_e'(bus.sign_sub);
      diff_p1 <= a_sx - b_sx;
      mode_p1 <= mode_p0;
    end
  end

  // S3 saturate/truncate into the output register.
  fxp_sat_trunc #(
    .EW    (EW),
    .HF    (HF),
    .OUT_I (OUT_I),
    .OUT_F (OUT_F)
  ) u_sat_trunc (
    .x     (diff_p1),
    .mode  (mode_p1),
    .y     (st_y),
    .flags (st_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      diff_p2  <= '0;
      flags_p2 <= '0;
    end else if (adv) begin
      vld_p0   <= bus.in_valid;
      vld_p1   <= vld_p0;
      vld_p2   <= vld_p1;
      diff_p2  <= st_y;
      flags_p2 <= st_flags;
    end
  end

  // A flag arriving with the handshake takes priority over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      if (fire & flags_p2[FLG_OVF]) sticky_ovf <= 1'b1;
      else if (clr_sticky)          sticky_ovf <= 1'b0;
      if (fire & flags_p2[FLG_UNF]) sticky_unf <= 1'b1;
      else if (clr_sticky)          sticky_unf <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.diff      = diff_p2;
  assign bus.overflow  = flags_p2[FLG_OVF];
  assign bus.underflow = flags_p2[FLG_UNF];

endmodule

// File: tb/tb_fxp_sub_pipe.sv
// Bench for fxp_sub_pipe: four output formats (Q5.5, Q4.5, Q5.3, Q2.3) fed in
// lockstep from one operand stream, checked against a scoreboard of constants.
module tb_fxp_sub_pipe;

  typedef struct packed {
    logic [8:0] a;
    logic [8:0] b;
    logic       sgn;
    logic [9:0] d55;
    logic [8:0] d45;
    logic [7:0] d53;
    logic [4:0] d23;
    logic [3:0] ovf;  // bit0 Q5.5, bit1 Q4.5, bit2 Q5.3, bit3 Q2.3
    logic [3:0] unf;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [8:0] op_a;
  logic [8:0] op_b;
  logic       sgn;
  logic       out_ready;
  logic       clr_sticky;
  logic [3:0] sov;
  logic [3:0] sun;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  vec_t sb[$];
  vec_t tbl[8];
  vec_t e;
  logic       stalled_q = 1'b0;
  logic [9:0] held = '0;

  fxp_sub_pipe_if #(.A_W(9), .B_W(9), .D_W(10)) if55 ();
  fxp_sub_pipe_if #(.A_W(9), .B_W(9), .D_W(9))  if45 ();
  fxp_sub_pipe_if #(.A_W(9), .B_W(9), .D_W(8))  if53 ();
  fxp_sub_pipe_if #(.A_W(9), .B_W(9), .D_W(5))  if23 ();

  assign if55.in_valid = in_valid;  assign if45.in_valid = in_valid;
  assign if53.in_valid = in_valid;  assign if23.in_valid = in_valid;
  assign if55.a = op_a;             assign if45.a = op_a;
  assign if53.a = op_a;             assign if23.a = op_a;
  assign if55.b = op_b;             assign if45.b = op_b;
  assign if53.b = op_b;             assign if23.b = op_b;
  assign if55.sign_sub = sgn;       assign if45.sign_sub = sgn;
  assign if53.sign_sub = sgn;       assign if23.sign_sub = sgn;
  assign if55.out_ready = out_ready; assign if45.out_ready = out_ready;
  assign if53.out_ready = out_ready; assign if23.out_ready = out_ready;

  fxp_sub_pipe #(.OUT_I(5), .OUT_F(5)) dut55 (
    .clk(clk), .rst(rst), .bus(if55), .clr_sticky(clr_sticky),
    .sticky_ovf(sov[0]), .sticky_unf(sun[0]));
  fxp_sub_pipe #(.OUT_I(4), .OUT_F(5)) dut45 (
    .clk(clk), .rst(rst), .bus(if45), .clr_sticky(clr_sticky),
    .sticky_ovf(sov[1]), .sticky_unf(sun[1]));
  fxp_sub_pipe #(.OUT_I(5), .OUT_F(3)) dut53 (
    .clk(clk), .rst(rst), .bus(if53), .clr_sticky(clr_sticky),
    .sticky_ovf(sov[2]), .sticky_unf(sun[2]));
  fxp_sub_pipe #(.OUT_I(2), .OUT_F(3)) dut23 (
    .clk(clk), .rst(rst), .bus(if23), .clr_sticky(clr_sticky),
    .sticky_ovf(sov[3]), .sticky_unf(sun[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [8:0] a, input logic [8:0] b, input logic s,
                              input logic [9:0] d55, input logic [8:0] d45,
                              input logic [7:0] d53, input logic [4:0] d23,
                              input logic [3:0] o, input logic [3:0] u);
    vec_t v;
    v.a = a; v.b = b; v.sgn = s;
    v.d55 = d55; v.d45 = d45; v.d53 = d53; v.d23 = d23;
    v.ovf = o; v.unf = u;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (if55.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: got an output, expected none pending");
        end else begin
          e = sb.pop_front();
          n_pop++;
          check("diff55", 32'(if55.diff), 32'(e.d55));
          check("diff45", 32'(if45.diff), 32'(e.d45));
          check("diff53", 32'(if53.diff), 32'(e.d53));
          check("diff23", 32'(if23.diff), 32'(e.d23));
          check("ovf", 32'({if23.overflow, if53.overflow, if45.overflow, if55.overflow}),
                32'(e.ovf));
          check("unf", 32'({if23.underflow, if53.underflow, if45.underflow, if55.underflow}),
                32'(e.unf));
          check("valid_align", 32'({if23.out_valid, if53.out_valid, if45.out_valid}), 32'(3'b111));
        end
      end
      if (if55.out_valid && !out_ready) check("in_ready_stall", 32'(if55.in_ready), 32'(0));
      if (stalled_q && if55.out_valid) check("diff_hold", 32'(if55.diff), 32'(held));
      stalled_q = if55.out_valid && !out_ready;
      held      = if55.diff;
    end else begin
      stalled_q = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input vec_t v);
    int  waitc = 0;
    bit  done  = 0;
    in_valid = 1'b1;
    op_a = v.a;
    op_b = v.b;
    sgn  = v.sgn;
    while (!done) begin
      @(negedge clk);
      if (if55.in_ready) begin
        sb.push_back(v);
        n_push++;
        done = 1;
      end
      @(posedge clk);
      #1;
      waitc++;
      if (!done && waitc > 50) begin
        check("send_timeout", 32'(0), 32'(1));
        done = 1;
      end
    end
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  task automatic pulse_clr();
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
  endtask

  initial begin
    int c;
    int n;
    //         a       b       s     Q5.5     Q4.5    Q5.3   Q2.3   ovf      unf
    tbl[0] = mk(9'h0F0, 9'h100, 1'b1, 10'h1F0, 9'h0FF, 8'h7C, 5'h0F, 4'b1010, 4'b0000);
    tbl[1] = mk(9'h100, 9'h0F0, 1'b1, 10'h210, 9'h100, 8'h84, 5'h10, 4'b1010, 4'b0000);
    tbl[2] = mk(9'h000, 9'h020, 1'b0, 10'h000, 9'h000, 8'h00, 5'h00, 4'b1111, 4'b0000);
    tbl[3] = mk(9'h003, 9'h000, 1'b1, 10'h003, 9'h003, 8'h01, 5'h01, 4'b0000, 4'b1100);
    tbl[4] = mk(9'h1FF, 9'h001, 1'b0, 10'h1FE, 9'h1FE, 8'h7F, 5'h1F, 4'b1000, 4'b1100);
    tbl[5] = mk(9'h000, 9'h001, 1'b1, 10'h3FF, 9'h1FF, 8'hFF, 5'h1F, 4'b0000, 4'b1100);
    tbl[6] = mk(9'h100, 9'h0F0, 1'b0, 10'h010, 9'h010, 8'h04, 5'h04, 4'b0000, 4'b0000);
    tbl[7] = mk(9'h1F0, 9'h020, 1'b1, 10'h3D0, 9'h1D0, 8'hF4, 5'h14, 4'b0000, 4'b0000);

    rst = 1'b1;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sgn = 1'b0;
    out_ready = 1'b1;
    clr_sticky = 1'b0;
    #3;
    check("rst_out_valid", 32'(if55.out_valid), 32'(0));
    check("rst_diff55", 32'(if55.diff), 32'(0));
    check("rst_diff23", 32'(if23.diff), 32'(0));
    check("rst_flags", 32'({if55.overflow, if55.underflow}), 32'(0));
    check("rst_sticky", 32'({sov, sun}), 32'(0));
    check("rst_in_ready", 32'(if55.in_ready), 32'(1));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-rate pass over the vector table.
    for (int i = 0; i < 8; i++) send(tbl[i]);
    in_valid = 1'b0;
    drain();
    check("sticky_ovf_all", 32'(sov), 32'(4'hF));
    check("sticky_unf_all", 32'(sun), 32'(4'hC));

    pulse_clr();
    check("clr_ovf", 32'(sov), 32'(0));
    check("clr_unf", 32'(sun), 32'(0));

    // Jam result held at the output, then clear coinciding with its handshake.
    out_ready = 1'b0;
    send(tbl[3]);
    in_valid = 1'b0;
    c = 0;
    while (!if55.out_valid && c < 10) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("stall_valid", 32'(if55.out_valid), 32'(1));
    check("stall_no_sticky", 32'(sun), 32'(0));
    out_ready = 1'b1;
    pulse_clr();
    check("set_wins_unf", 32'(sun), 32'(4'hC));
    check("set_wins_ovf", 32'(sov), 32'(0));
    pulse_clr();
    check("clr_unf2", 32'(sun), 32'(0));

    // Backpressure: out_ready pattern 1,0,0 repeating.
    fork
      begin
        for (int i = 0; i < 6; i++) send(tbl[i]);
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 30; k++) begin
          out_ready = (k % 3 == 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("pop_count", 32'(n_pop), 32'(n_push));

    // Asynchronous reset with three results in flight.
    send(tbl[2]);
    send(tbl[4]);
    send(tbl[0]);
    send(tbl[1]);
    in_valid = 1'b0;
    check("pre_rst_sticky", 32'(sov), 32'(4'hF));
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'({if23.out_valid, if53.out_valid, if45.out_valid, if55.out_valid}),
          32'(0));
    check("async_sticky", 32'({sov, sun}), 32'(0));
    check("async_diff", 32'(if55.diff), 32'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First operand after reset: count edges until its result is valid.
    in_valid = 1'b1;
    op_a = tbl[7].a;
    op_b = tbl[7].b;
    sgn  = tbl[7].sgn;
    sb.push_back(tbl[7]);
    n = 0;
    c = 0;
    while (c == 0 && n < 10) begin
      @(posedge clk);
      n++;
      #1;
      in_valid = 1'b0;
      if (if55.out_valid) c = 1;
    end
    check("latency", 32'(n), 32'(3));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
